// File: rtl/fft_frame_serializer_pkg.sv
// fft_frame_serializer_pkg: shared sample type, read FSM states and bit-reverse helper.
package fft_frame_serializer_pkg;
  localparam int SAMPLE_W = 16;
  typedef struct packed {
    logic signed [SAMPLE_W-1:0] r;
    logic signed [SAMPLE_W-1:0] i;
  } complex_product_t;
  typedef enum logic {IDLE, STREAM} rd_state_e;
  function automatic int unsigned bitrev(input int unsigned k, input int unsigned bits);
    int unsigned v;
    v = 0;
    for (int unsigned b = 0; b < bits; b++) v = (v << 1) | ((k >> b) & 32'd1);
    return v;
  endfunction
endpackage

// File: rtl/fft_frame_serializer_bank.sv
// fft_frame_bank: one N-sample frame register with whole-frame write and indexed read.
module fft_frame_bank
  import fft_frame_serializer_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                          clk,
  input  logic                          we,
  input  complex_product_t [N-1:0]      din,
  input  logic [$clog2(N)-1:0]          rd_idx,
  output complex_product_t              dout
);
  complex_product_t [N-1:0] mem_q, mem_d;
  always_comb mem_d = we ? din : mem_q;
  always_ff @(posedge clk) mem_q <= mem_d;
  assign dout = mem_q[rd_idx];
endmodule

// File: rtl/fft_frame_serializer.sv
// fft_frame_serializer: ping-pong capture of parallel FFT frames, streamed out one sample per transfer.
// Define FFT_SER_BITREV_EN to reorder bit-reversed FFT output into natural order.
module fft_frame_serializer
  import fft_frame_serializer_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  complex_product_t [N-1:0] frame_in,
  input  logic                     frame_valid,
  output logic                     frame_ready,
  output complex_product_t         data_out,
  output logic                     data_valid,
  input  logic                     data_ready,
  output logic                     sof,
  output logic                     eof,
  output logic [$clog2(N)-1:0]     sample_idx,
  output logic                     overflow
);
  localparam int IDX_W = $clog2(N);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);
  rd_state_e state_q, state_d;
  logic [1:0] full_q, full_d;
  logic wr_ptr_q, wr_ptr_d, rd_bank_q, rd_bank_d, overflow_q, overflow_d;
  logic [IDX_W-1:0] cnt_q, cnt_d, rd_idx;
  logic capture, xfer, last_xfer;
  logic [1:0] we;
  complex_product_t bank_dout [2];
  assign frame_ready = ~&full_q;
  assign capture     = frame_valid & frame_ready;
  assign data_valid  = state_q == STREAM;
  assign xfer        = data_valid & data_ready;
  assign last_xfer   = xfer & (cnt_q == LAST);
  assign we          = capture ? (wr_ptr_q ? 2'b10 : 2'b01) : 2'b00;
`ifdef FFT_SER_BITREV_EN
  assign rd_idx = IDX_W'(bitrev(32'(cnt_q), IDX_W));
`else
  assign rd_idx = cnt_q;
`endif
  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_frame_bank #(.N(N)) u_bank (
      .clk    (clk),
      .we     (we[b]),
      .din    (frame_in),
      .rd_idx (rd_idx),
      .dout   (bank_dout[b])
    );
  end
  // write pointer always lands on the empty bank, so frees and captures never collide
  always_comb begin
    full_d = full_q;
    if (last_xfer) full_d[rd_bank_q] = 1'b0;
    if (capture) full_d[wr_ptr_q] = 1'b1;
    wr_ptr_d   = wr_ptr_q ^ capture;
    rd_bank_d  = rd_bank_q ^ last_xfer;
    cnt_d      = xfer ? cnt_q + IDX_W'(1) : cnt_q;
    overflow_d = overflow_q | (frame_valid & ~frame_ready);
    state_d    = state_q == IDLE ? (capture ? STREAM : IDLE)
                                 : ((last_xfer && !full_d[~rd_bank_q]) ? IDLE : STREAM);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      full_q     <= '0;
      wr_ptr_q   <= 1'b0;
      rd_bank_q  <= 1'b0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      full_q     <= full_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_bank_q  <= rd_bank_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
    end
  end
  assign data_out   = data_valid ? bank_dout[rd_bank_q] : '0;
  assign sof        = data_valid & (cnt_q == '0);
  assign eof        = data_valid & (cnt_q == LAST);
  assign sample_idx = cnt_q;
  assign overflow   = overflow_q;
endmodule

// File: doc/fft_frame_serializer.md
FFT_FRAME_SERIALIZER -- requirements
Module: fft_frame_serializer

Interface
REQ-001 SHALL have parameter N, default 8, meaning complex samples per frame; power of two, N >= 2.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic on posedge.
REQ-003 SHALL have port reset, input, 1, synchronous active-low reset (asserted when 0).
REQ-004 SHALL have port frame_in, input, N x complex_product_t, parallel FFT result frame.
REQ-005 SHALL have port frame_valid, input, 1, frame_in valid this cycle.
REQ-006 SHALL have port frame_ready, output, 1, a frame bank is free to capture.
REQ-007 SHALL have port data_out, output, complex_product_t, serial sample.
REQ-008 SHALL have port data_valid, output, 1, data_out valid.
REQ-009 SHALL have port data_ready, input, 1, downstream accepts data_out.
REQ-010 SHALL have ports sof and eof, outputs, 1 each, first and last sample of a frame.
REQ-011 SHALL have port sample_idx, output, $clog2(N), output-order index of data_out.
REQ-012 SHALL have port overflow, output, 1, sticky flag for a frame offered while frame_ready=0.

Function
REQ-013 SHALL hold two frame banks (ping-pong); each bank is EMPTY or FULL.
REQ-014 SHALL drive frame_ready=1 whenever at least one bank is EMPTY, combinationally from bank state only.
REQ-015 SHALL capture frame_in into an EMPTY bank on posedge when frame_valid && frame_ready; write order alternates bank 0, bank 1, bank 0, ...
REQ-016 SHALL ignore frame_valid && !frame_ready (no bank changes) and set overflow to 1 until reset.
REQ-017 SHALL use read FSM states IDLE (no FULL bank) and STREAM (reading active bank); IDLE->STREAM when a bank becomes FULL; STREAM->STREAM on last-sample transfer if the other bank is FULL; otherwise STREAM->IDLE.
REQ-018 SHALL present the first sample of a captured frame with data_valid=1 in the cycle after capture (latency 1 from IDLE).
REQ-019 SHALL advance the read counter only on data_valid && data_ready; hold data_out, sof, eof, sample_idx stable while data_valid && !data_ready.
REQ-020 SHALL assert sof with counter 0 and eof with counter N-1; counter wraps N-1 -> 0.
REQ-021 SHALL mark the active bank EMPTY on the eof transfer and, if the other bank is FULL, present its sample 0 in the next cycle with no bubble.
REQ-022 SHALL permit, in one cycle, capture into one bank while the other is freed by its eof transfer; capture goes to the freed bank only if it was already EMPTY before that cycle.
REQ-023 SHALL pass samples bit-exact; no arithmetic or width change.
REQ-024 SHALL drive data_valid=0 in IDLE; data_out value is don't-care when data_valid=0.

Reset
REQ-025 SHALL, on reset=0 at posedge, set both banks EMPTY, FSM IDLE, counter 0, write pointer bank 0, overflow 0, data_valid/sof/eof 0, sample_idx 0, data_out 0.
REQ-026 SHALL discard any in-flight or buffered frame when reset is asserted mid-stream; frame_ready=1 the first cycle after release.

Configuration
REQ-027 SHALL honour macro FFT_SER_BITREV_EN: defined -> sample at counter k is frame_in[bitrev(k)] and sample_idx=k (natural order from bit-reversed FFT output); undefined -> sample at counter k is frame_in[k].

Structure
REQ-028 SHALL take complex_product_t and the bit-reverse function from the shared header/package; no local redefinition.
REQ-029 SHALL instantiate sub-module fft_frame_bank (one N-sample register bank with write-enable and indexed read) twice.

Verification
REQ-030 Single frame, N=8, frame_in[k].r=k, .i=-k, data_ready=1 -> 8 consecutive valid samples next cycle, sof on first, eof on eighth, r=0..7 (bitrev build: 0,4,2,6,1,5,3,7).
REQ-031 Back-to-back frames A then B one cycle apart, data_ready=1 -> 16 contiguous valid cycles, no bubble at A eof/B sof, frame_ready low only while both FULL.
REQ-032 Third frame offered while both banks FULL -> frame ignored, overflow=1 and stays 1, output stream of A and B unchanged.
REQ-033 data_ready toggling 1,0,0,1 during a frame -> data_out/sample_idx held across the 0 cycles, no sample lost or repeated.
REQ-034 reset=0 asserted at sample 3 of a frame -> next cycle data_valid=0, overflow=0, frame_ready=1; a new frame afterward starts at sof, sample_idx 0.
REQ-035 eof transfer coincident with frame_valid into the other, EMPTY bank -> capture succeeds, next frame begins the following cycle.
